dccm_port_arbiter: RTL and testbench

Shares the single-port DCCM between the LSU and a DMA/loader port (program/data preload, debug access). LSU has priority. A saturating starvation counter guarantees DMA forward progress, and a one-beat lock keeps the two halves of an LSU unaligned access back-to-back. The block sits between the LSU and the DCCM inside the execution unit. It also steers one-cycle-late read data back to the requester that issued the read.

---
 rtl/dccm_port_arbiter.sv | 127 ++++++++++++
 tb/tb_dccm_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dccm_port_arbiter.sv
// dccm_port_arbiter: shares the single-port DCCM between the LSU and a DMA/loader
// port. The LSU normally wins; a saturating starvation counter forces a pending DMA
// request through, and a one-beat lock keeps both halves of an unaligned LSU access
// back-to-back. Read data returns one cycle after the grant to whoever issued the read.
module dccm_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // LSU port
  input  logic              lsu_req,
  input  logic              lsu_wen,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [XLEN/8-1:0] lsu_wmask,
  input  logic              lsu_lock,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [XLEN-1:0]   lsu_rdata,
  // DMA / loader port
  input  logic              dma_valid,
  input  logic              dma_wen,
  input  logic [XLEN-1:0]   dma_addr,
  input  logic [XLEN-1:0]   dma_wdata,
  input  logic [XLEN/8-1:0] dma_wmask,
  output logic              dma_ready,
  output logic              dma_rvalid,
  output logic [XLEN-1:0]   dma_rdata,
  // DCCM port
  output logic              dccm_en,
  output logic              dccm_wen,
  output logic [XLEN-1:0]   dccm_addr,
  output logic [XLEN-1:0]   dccm_wdata,
  output logic [XLEN/8-1:0] dccm_wmask,
  input  logic [XLEN-1:0]   dccm_rdata
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic {NORMAL, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          starved;
  logic          rd_valid_q;  // a read was granted last cycle
  logic          rd_owner_q;  // 0 = LSU, 1 = DMA

  assign starved = (starve_q == LIMIT);

  // Grant decision and next state. Nothing is granted while reset is held.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    lsu_gnt   = 1'b0;
    dma_ready = 1'b0;
    state_d   = NORMAL;
    if (rst_n) begin
      unique case (state_q)
        NORMAL: begin
          // DMA wins when it is alone or has waited the full starvation budget.
          dma_ready = dma_valid & (~lsu_req | starved);
          lsu_gnt   = lsu_req & ~dma_ready;
          if (lsu_gnt && lsu_lock) state_d = LOCKED;
        end
        LOCKED: begin
          // Second beat of an unaligned access; lsu_lock is ignored here so the
          // lock never extends past one beat.
          lsu_gnt = lsu_req;
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: counts refused DMA cycles, saturating at the limit.
  always_comb begin
    starve_d = '0;
    if (dma_valid && !dma_ready) starve_d = starved ? starve_q : starve_q + SW'(1);
  end

  // DCCM request mux: the winner's fields, or all zeros when idle.
  always_comb begin
    dccm_en    = 1'b0;
    dccm_wen   = 1'b0;
    dccm_addr  = '0;
    dccm_wdata = '0;
    dccm_wmask = '0;
    if (lsu_gnt) begin
      dccm_en    = 1'b1;
      dccm_wen   = lsu_wen;
      dccm_addr  = lsu_addr;
      dccm_wdata = lsu_wdata;
      dccm_wmask = lsu_wmask;
    end else if (dma_ready) begin
      dccm_en    = 1'b1;
      dccm_wen   = dma_wen;
      dccm_addr  = dma_addr;
      dccm_wdata = dma_wdata;
      dccm_wmask = dma_wmask;
    end
  end

  // State, counter and read-return tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_valid_q <= (lsu_gnt & ~lsu_wen) | (dma_ready & ~dma_wen);
      rd_owner_q <= dma_ready;
    end
  end

  assign lsu_rvalid = rd_valid_q & ~rd_owner_q;
  assign dma_rvalid = rd_valid_q &  rd_owner_q;
  assign lsu_rdata  = dccm_rdata;
  assign dma_rdata  = dccm_rdata;

endmodule

// File: tb/tb_dccm_port_arbiter.sv
// Testbench for dccm_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model of the arbitration rules
// and a behavioural DCCM kept in the bench.
module tb_dccm_port_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              lsu_req, lsu_wen, lsu_lock;
  logic [XLEN-1:0]   lsu_addr, lsu_wdata;
  logic [XLEN/8-1:0] lsu_wmask;
  logic              lsu_gnt, lsu_rvalid;
  logic [XLEN-1:0]   lsu_rdata;
  logic              dma_valid, dma_wen;
  logic [XLEN-1:0]   dma_addr, dma_wdata;
  logic [XLEN/8-1:0] dma_wmask;
  logic              dma_ready, dma_rvalid;
  logic [XLEN-1:0]   dma_rdata;
  logic              dccm_en, dccm_wen;
  logic [XLEN-1:0]   dccm_addr, dccm_wdata;
  logic [XLEN/8-1:0] dccm_wmask;
  logic [XLEN-1:0]   dccm_rdata;

  dccm_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_lock(lsu_lock), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .dma_valid(dma_valid), .dma_wen(dma_wen), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_wmask(dma_wmask), .dma_ready(dma_ready), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .dccm_en(dccm_en), .dccm_wen(dccm_wen), .dccm_addr(dccm_addr),
    .dccm_wdata(dccm_wdata), .dccm_wmask(dccm_wmask), .dccm_rdata(dccm_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural DCCM contents, keyed by word address.
  logic [XLEN-1:0] mem [logic [XLEN-1:0]];

  // Reference model state.
  int              m_refused;     // consecutive cycles the pending DMA request was refused
  bit              m_lock_beat;   // the next cycle is the locked second LSU beat
  bit              m_rd_pending;  // a read was granted last cycle
  bit              m_rd_dma;      // ... and it belonged to the DMA
  logic [XLEN-1:0] m_rd_data;     // value that read must return
  logic [XLEN-1:0] dccm_ret;      // value the bench DCCM will present next cycle

  // Last sampled DUT outputs, for directed checks.
  logic            obs_lsu_gnt, obs_dma_ready, obs_lsu_rvalid, obs_dma_rvalid;
  logic [XLEN-1:0] obs_lsu_rdata, obs_dma_rdata;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] mem_rd(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] wa;
    wa = a & ~32'h3;
    return mem.exists(wa) ? mem[wa] : '0;
  endfunction

  task automatic mem_wr(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                        input logic [XLEN/8-1:0] m);
    logic [XLEN-1:0] v;
    v = mem_rd(a);
    for (int b = 0; b < XLEN/8; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    mem[a & ~32'h3] = v;
  endtask

  task automatic model_reset();
    m_refused    = 0;
    m_lock_beat  = 0;
    m_rd_pending = 0;
    m_rd_dma     = 0;
  endtask

  // One clock cycle: inputs are already applied; check at the falling edge, update
  // the model, act as the DCCM, and return just after the next rising edge.
  task automatic cycle();
    bit              want_lsu, want_dma;
    logic            e_en, e_wen;
    logic [XLEN-1:0] e_addr, e_wdata;
    logic [XLEN/8-1:0] e_wmask;
    @(negedge clk);
    // Arbitration rules: a locked beat belongs to the LSU; otherwise the DMA wins
    // when it is alone or has been refused LIMIT times in a row.
    if (m_lock_beat) begin
      want_lsu = lsu_req;
      want_dma = 0;
    end else begin
      want_dma = dma_valid && (!lsu_req || m_refused >= LIMIT);
      want_lsu = lsu_req && !want_dma;
    end
    check("lsu_gnt", lsu_gnt, want_lsu);
    check("dma_ready", dma_ready, want_dma);
    e_en = want_lsu || want_dma;
    e_wen = 0; e_addr = '0; e_wdata = '0; e_wmask = '0;
    if (want_lsu) begin e_wen = lsu_wen; e_addr = lsu_addr; e_wdata = lsu_wdata; e_wmask = lsu_wmask; end
    if (want_dma) begin e_wen = dma_wen; e_addr = dma_addr; e_wdata = dma_wdata; e_wmask = dma_wmask; end
    check("dccm_en", dccm_en, e_en);
    check("dccm_wen", dccm_wen, e_wen);
    check("dccm_addr", dccm_addr, e_addr);
    check("dccm_wdata", dccm_wdata, e_wdata);
    check("dccm_wmask", dccm_wmask, e_wmask);
    check("lsu_rvalid", lsu_rvalid, m_rd_pending && !m_rd_dma);
    check("dma_rvalid", dma_rvalid, m_rd_pending && m_rd_dma);
    if (m_rd_pending && !m_rd_dma) check("lsu_rdata", lsu_rdata, m_rd_data);
    if (m_rd_pending &&  m_rd_dma) check("dma_rdata", dma_rdata, m_rd_data);
    if (want_dma) check("dma_wait_bound", (m_refused <= LIMIT + 1), 1);
    obs_lsu_gnt = lsu_gnt;       obs_dma_ready = dma_ready;
    obs_lsu_rvalid = lsu_rvalid; obs_dma_rvalid = dma_rvalid;
    obs_lsu_rdata = lsu_rdata;   obs_dma_rdata = dma_rdata;
    // Bench DCCM reacts to what the DUT actually drives.
    dccm_ret = $urandom;
    if (dccm_en && !dccm_wen) dccm_ret = mem_rd(dccm_addr);
    // Model: expected read return comes from the requester's own address.
    m_rd_pending = (want_lsu && !lsu_wen) || (want_dma && !dma_wen);
    m_rd_dma     = want_dma;
    m_rd_data    = want_dma ? mem_rd(dma_addr) : mem_rd(lsu_addr);
    if (dccm_en && dccm_wen) mem_wr(dccm_addr, dccm_wdata, dccm_wmask);
    m_refused   = (dma_valid && !want_dma) ? m_refused + 1 : 0;
    m_lock_beat = !m_lock_beat && want_lsu && lsu_lock;
    @(posedge clk);
    #1;
    dccm_rdata = dccm_ret;
  endtask

  // Hold reset with every request high, check the quiet outputs, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    lsu_req = 1; lsu_lock = 1; dma_valid = 1;
    dccm_rdata = '0;
    model_reset();
    @(negedge clk);
    check("rst_lsu_gnt", lsu_gnt, 0);
    check("rst_dma_ready", dma_ready, 0);
    check("rst_dccm_en", dccm_en, 0);
    check("rst_dccm_wen", dccm_wen, 0);
    check("rst_dccm_addr", dccm_addr, 0);
    check("rst_lsu_rvalid", lsu_rvalid, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_lsu_rdata", lsu_rdata, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lsu_lock = 0;
  endtask

  task automatic set_lsu(input bit req, input bit wen, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] d, input bit lock);
    lsu_req = req; lsu_wen = wen; lsu_addr = a; lsu_wdata = d; lsu_wmask = 4'hF; lsu_lock = lock;
  endtask

  task automatic set_dma(input bit v, input bit wen, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] d);
    dma_valid = v; dma_wen = wen; dma_addr = a; dma_wdata = d; dma_wmask = 4'hF;
  endtask

  initial begin
    int slot;
    set_lsu(0, 0, '0, '0, 0);
    set_dma(0, 0, '0, '0);
    rst_n = 1'b0;
    dccm_rdata = '0;

    // Reset, then first cycle goes to the LSU; LSU read of 0x100 returns next cycle.
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h300] = 32'h0BADF00D;
    do_reset();
    set_lsu(1, 0, 32'h100, '0, 0);
    set_dma(1, 0, 32'h300, '0);
    cycle();
    check("first_gnt_lsu", obs_lsu_gnt, 1);
    set_lsu(0, 0, '0, '0, 0);
    cycle();
    check("lsu_read_rvalid", obs_lsu_rvalid, 1);
    check("lsu_read_data", obs_lsu_rdata, 32'hDEADBEEF);
    check("lsu_read_no_dma_rvalid", obs_dma_rvalid, 0);
    set_dma(0, 0, '0, '0);
    cycle();
    check("dma_read_data", obs_dma_rdata, 32'h0BADF00D);

    // Continuous LSU traffic against a DMA write: forced through in cycle LIMIT.
    do_reset();
    set_dma(1, 1, 32'h200, 32'h12345678);
    slot = -1;
    for (int i = 0; i < 8; i++) begin
      set_lsu(1, 0, 32'($urandom_range(0, 15)) << 2, '0, 0);
      cycle();
      if (obs_dma_ready) begin slot = i; break; end
    end
    check("starve_slot", slot, LIMIT);
    check("forced_lsu_gnt", obs_lsu_gnt, 0);
    check("dma_write_commit", mem_rd(32'h200), 32'h12345678);
    set_dma(0, 0, '0, '0);
    cycle();
    check("lsu_after_force", obs_lsu_gnt, 1);

    // Locked pair issued as the counter saturates: beat 2 to LSU, DMA the cycle after.
    do_reset();
    set_dma(1, 0, 32'h40, '0);
    set_lsu(1, 0, 32'h44, '0, 0);
    for (int i = 0; i < 3; i++) cycle();
    lsu_lock = 1;
    cycle();
    check("lock_beat1", obs_lsu_gnt, 1);
    set_lsu(1, 0, 32'h48, '0, 1);
    cycle();
    check("lock_beat2_lsu", obs_lsu_gnt, 1);
    check("lock_beat2_dma", obs_dma_ready, 0);
    set_lsu(1, 0, 32'h4C, '0, 0);
    cycle();
    check("after_lock_dma", obs_dma_ready, 1);
    check("after_lock_lsu", obs_lsu_gnt, 0);

    // Alternating owners with distinct data.
    mem[32'h10] = 32'hA;
    mem[32'h20] = 32'hB;
    set_dma(0, 0, '0, '0);
    set_lsu(1, 0, 32'h10, '0, 0);
    cycle();
    set_lsu(0, 0, '0, '0, 0);
    set_dma(1, 0, 32'h20, '0);
    cycle();
    check("alt_lsu_rvalid", obs_lsu_rvalid, 1);
    check("alt_lsu_rdata", obs_lsu_rdata, 32'hA);
    check("alt_lsu_only", obs_dma_rvalid, 0);
    set_dma(0, 0, '0, '0);
    cycle();
    check("alt_dma_rvalid", obs_dma_rvalid, 1);
    check("alt_dma_rdata", obs_dma_rdata, 32'hB);
    check("alt_dma_only", obs_lsu_rvalid, 0);

    // Reset the cycle after a granted DMA read: return dropped, counter cleared.
    set_dma(1, 0, 32'h20, '0);
    cycle();
    check("pre_reset_dma_gnt", obs_dma_ready, 1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_drops_rvalid", dma_rvalid, 0);
    do_reset();
    set_lsu(1, 0, 32'h8, '0, 0);
    set_dma(1, 0, 32'hC, '0);
    cycle();
    check("post_reset_lsu_first", obs_lsu_gnt, 1);
    check("post_reset_dma_wait", obs_dma_ready, 0);

    // Randomized traffic obeying the requester hold rules.
    for (int i = 0; i < 600; i++) begin
      if (!lsu_req || obs_lsu_gnt)
        set_lsu(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                32'($urandom_range(0, 15)) << 2, $urandom, ($urandom_range(0, 3) == 0));
      if (lsu_req) lsu_wmask = (lsu_wen) ? 4'($urandom_range(1, 15)) : 4'hF;
      if (!dma_valid || obs_dma_ready) begin
        set_dma(($urandom_range(0, 9) < 5), $urandom_range(0, 1),
                32'($urandom_range(0, 15)) << 2, $urandom);
        if (dma_wen) dma_wmask = 4'($urandom_range(1, 15));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
